bcd_serial_add_ctrl: RTL and testbench

- Digit-serial controller for multi-digit packed-BCD addition.
- Latches two DIGITS-wide BCD operands, then drives one internal single-digit BCD add stage once per cycle, LSD first.
- Ripples the decimal carry through a register and assembles the packed result.
- Sits between a host issuing Start/Done transactions and the shared one-digit decimal adder datapath.

---
 rtl/bcd_serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller: one decimal digit per cycle, LSD first.
// Optional macro BCD_DIGIT_CHECK_EN adds a sticky Invalid flag for non-BCD input digits.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   augend_i,
  input  logic [4*DIGITS-1:0]   addend_i,
  input  logic                  carry_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   sum_o,
  output logic                  carry_out_o
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                  invalid_o
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS < 2) ? 1 : $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q, busy_q, done_q, cout_q;

  logic [4:0]      z_d;
  logic            c_d;
  logic [3:0]      dig_d;
  logic            last_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    z_d    = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
    c_d    = z_d[4] | (z_d[3] & z_d[2]) | (z_d[3] & z_d[1]);
    dig_d  = z_d[3:0];
    if (c_d) dig_d = z_d[3:0] + 4'd6;
    last_d = (cnt_q == CW'(DIGITS - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only; all registers,
  // including the operand shift registers, are cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= S_ADD;
            a_q     <= augend_i;
            b_q     <= addend_i;
            carry_q <= carry_in_i;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_ADD: begin
          // Result digits enter at the MSD end so digit 0 lands in [3:0] after DIGITS shifts.
          sum_q   <= (sum_q >> 4) | (W'(dig_d) << (W - 4));
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= c_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last_d) begin
            state_q <= S_DONE;
            cout_q  <= c_d;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sum_o       = sum_q;
  assign carry_out_o = cout_q;

`ifdef BCD_DIGIT_CHECK_EN
  logic invalid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      invalid_q <= 1'b0;
    end else if (state_q == S_IDLE && start_i) begin
      invalid_q <= 1'b0;
    end else if (state_q == S_ADD && (a_q[3:0] > 4'd9 || b_q[3:0] > 4'd9)) begin
      invalid_q <= 1'b1;
    end
  end

  assign invalid_o = invalid_q;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: directed corner cases plus random
// operands compared against a digit-by-digit decimal reference model.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] augend = '0;
  logic [W-1:0] addend = '0;
  logic         carry_in = 1'b0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum;
`ifdef BCD_DIGIT_CHECK_EN
  logic         invalid;
`endif

  int errors = 0;
  int checks = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .augend_i    (augend),
    .addend_i    (addend),
    .carry_in_i  (carry_in),
    .busy_o      (busy),
    .done_o      (done),
    .sum_o       (sum),
    .carry_out_o (carry_out)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .invalid_o   (invalid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: per-digit integer arithmetic, decimal-adjusting any digit sum above 9.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    int c = cin;
    logic [W-1:0] s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      int z = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
      int d;
      if (z > 9) begin d = (z + 6) % 16; c = 1; end
      else       begin d = z;            c = 0; end
      s[4*i +: 4] = 4'(d);
    end
    return {c[0], s};
  endfunction

  function automatic logic ref_inv(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_operand(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++)
      v[4*i +: 4] = (allow_bad && ($urandom % 4 == 0)) ? 4'($urandom % 16) : 4'($urandom % 10);
    return v;
  endfunction

  // Launches one op at the next edge and checks timing, busy and the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input string tag);
    logic [W:0] exp = ref_add(a, b, cin);
    int cycles = 0;
    bit got = 0;
    bit busy_low = 0;
    @(negedge clk);
    augend = a; addend = b; carry_in = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    augend = ~a; addend = ~b; carry_in = ~cin;
    while (!got && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (!busy) busy_low = 1;
      if (done) got = 1;
    end
    check({tag, ".latency"}, 64'(cycles), 64'(DIGITS + 1));
    check({tag, ".busy_during"}, 64'(busy_low), 64'd0);
    check({tag, ".sum"}, 64'(sum), 64'(exp[W-1:0]));
    check({tag, ".cout"}, 64'(carry_out), 64'(exp[W]));
`ifdef BCD_DIGIT_CHECK_EN
    check({tag, ".invalid"}, 64'(invalid), 64'(ref_inv(a, b)));
`endif
    @(negedge clk);
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
    check({tag, ".sum_hold"}, 64'(sum), 64'(exp[W-1:0]));
  endtask

  initial begin
    logic [W:0] e1, e2;
    int done_cnt, first_done, second_done;

    // Reset state
    #1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.sum", 64'(sum), 64'd0);
    check("rst.cout", 64'(carry_out), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(16'h1234, 16'h5678, 1'b0, "d1234");
    run_op(16'h9999, 16'h0001, 1'b0, "d9999p1");
    run_op(16'h0000, 16'h0000, 1'b1, "dcin");
    run_op(16'h9999, 16'h9999, 1'b1, "dmax");

    // Start during busy is ignored
    e1 = ref_add(16'h2468, 16'h1357, 1'b0);
    done_cnt = 0; first_done = 0;
    @(negedge clk);
    augend = 16'h2468; addend = 16'h1357; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) begin augend = 16'h8888; addend = 16'h7777; carry_in = 1'b1; start = 1'b1; end
      if (k == 3) start = 1'b0;
      if (done) begin done_cnt++; if (first_done == 0) first_done = k; end
      if (k == 5) check("ign.sum", 64'(sum), 64'(e1[W-1:0]));
    end
    check("ign.done_count", 64'(done_cnt), 64'd1);
    check("ign.done_cycle", 64'(first_done), 64'(DIGITS + 1));
    check("ign.sum_hold", 64'(sum), 64'(e1[W-1:0]));

    // Start held high: back-to-back ops separated by one IDLE cycle
    e1 = ref_add(16'h0505, 16'h0505, 1'b1);
    e2 = ref_add(16'h4321, 16'h6789, 1'b0);
    done_cnt = 0; first_done = 0; second_done = 0;
    @(negedge clk);
    augend = 16'h0505; addend = 16'h0505; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    augend = 16'h4321; addend = 16'h6789; carry_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = k; else second_done = k;
      end
      if (k == 5) begin
        check("held.sum1", 64'(sum), 64'(e1[W-1:0]));
        check("held.cout1", 64'(carry_out), 64'(e1[W]));
      end
      if (k == 6) check("held.idle_gap", 64'(busy), 64'd0);
      if (k == 11) begin
        check("held.sum2", 64'(sum), 64'(e2[W-1:0]));
        check("held.cout2", 64'(carry_out), 64'(e2[W]));
        start = 1'b0;
      end
    end
    check("held.done_count", 64'(done_cnt), 64'd2);
    check("held.done1_cycle", 64'(first_done), 64'd5);
    check("held.done2_cycle", 64'(second_done), 64'd11);

    // Asynchronous reset mid-operation
    @(negedge clk);
    augend = 16'h9876; addend = 16'h5432; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst.busy", 64'(busy), 64'd0);
    check("mrst.done", 64'(done), 64'd0);
    check("mrst.sum", 64'(sum), 64'd0);
    check("mrst.cout", 64'(carry_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mrst.no_done", 64'(done_cnt), 64'd0);
    run_op(16'h0457, 16'h0368, 1'b0, "post_rst");

`ifdef BCD_DIGIT_CHECK_EN
    run_op(16'h00A0, 16'h0000, 1'b0, "inv_set");
    check("inv_set.flag", 64'(invalid), 64'd1);
    run_op(16'h0001, 16'h0002, 1'b0, "inv_clr");
    check("inv_clr.flag", 64'(invalid), 64'd0);
    check("inv_clr.sum", 64'(sum), 64'h0003);
`endif

    // Random operands, including occasional non-BCD digits
    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] ra, rb;
      ra = rand_operand(1'b1);
      rb = rand_operand(1'b1);
      run_op(ra, rb, 1'($urandom % 2), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
